// File: rtl/spi_sensor_responder.sv
// SPI mode-0 responder modelling an accelerometer register file.
// All SPI pins are oversampled on i_clk; nothing here is clocked by SCLK.
module spi_sensor_responder #(
    parameter int unsigned DEPTH     = 16,
    parameter logic [7:0]  DEVICE_ID = 8'hAD,
    parameter logic [7:0]  CMD_WRITE = 8'h0A,
    parameter logic [7:0]  CMD_READ  = 8'h0B
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_sclk,
    input  logic                     i_cs_n,
    input  logic                     i_mosi,
    output logic                     o_miso,
    output logic                     o_miso_oe,
    input  logic [7:0]               i_xSense,
    input  logic [7:0]               i_ySense,
    input  logic [7:0]               i_zSense,
    output logic                     o_wr_strobe,
    output logic [$clog2(DEPTH)-1:0] o_wr_addr,
    output logic [7:0]               o_wr_data,
    output logic                     o_busy
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [2:0] {IDLE, CMD, ADDR, WR_DATA, RD_DATA, IGNORE} state_t;

    state_t          state_q, state_d;
    logic            sclk_s1, sclk_s2, sclk_d;
    logic            cs_s1, cs_s2, cs_d;
    logic            mosi_s1, mosi_s2;
    logic            cs_fall, sclk_rise, sclk_fall, byte_done;
    logic [2:0]      bit_cnt;
    logic [6:0]      shift_in;
    logic [6:0]      shift_out;
    logic [7:0]      in_byte;
    logic            is_read;
    logic [AW-1:0]   addr;
    logic [AW-1:0]   rd_addr;
    logic [7:0]      rd_data;
    logic [7:0]      snap_x, snap_y, snap_z;
    logic [7:0]      regs [DEPTH];

    // Two-flop synchronizers plus one delay stage for edge detection.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            sclk_s1 <= 1'b0; sclk_s2 <= 1'b0; sclk_d <= 1'b0;
            cs_s1   <= 1'b1; cs_s2   <= 1'b1; cs_d   <= 1'b1;
            mosi_s1 <= 1'b0; mosi_s2 <= 1'b0;
        end else begin
            sclk_s1 <= i_sclk;  sclk_s2 <= sclk_s1; sclk_d <= sclk_s2;
            cs_s1   <= i_cs_n;  cs_s2   <= cs_s1;   cs_d   <= cs_s2;
            mosi_s1 <= i_mosi;  mosi_s2 <= mosi_s1;
        end
    end

    // SCLK edges only count inside a frame and lose to a coincident CS_n fall.
    assign cs_fall   = cs_d & ~cs_s2;
    assign sclk_rise = ~cs_s2 & ~cs_fall & sclk_s2 & ~sclk_d;
    assign sclk_fall = ~cs_s2 & ~cs_fall & ~sclk_s2 & sclk_d;
    assign in_byte   = {shift_in, mosi_s2};
    assign byte_done = sclk_rise && (bit_cnt == 3'd7);
    assign o_busy    = (state_q != IDLE);
    assign o_miso_oe = ~cs_s2;

    // Register-map read port; address is the one about to be presented on MISO.
    always_comb begin
        rd_addr = (state_q == ADDR) ? in_byte[AW-1:0] : addr + 1'b1;
        case (rd_addr)
            AW'(0):  rd_data = DEVICE_ID;
            AW'(1):  rd_data = snap_x;
            AW'(2):  rd_data = snap_y;
            AW'(3):  rd_data = snap_z;
            default: rd_data = regs[rd_addr];
        endcase
    end

    // FSM state register.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic; a deasserted CS_n always returns to IDLE.
    always_comb begin
        state_d = state_q;
        if (cs_s2) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (cs_fall) state_d = CMD;
                CMD:     if (byte_done)
                             state_d = (in_byte == CMD_WRITE || in_byte == CMD_READ) ? ADDR : IGNORE;
                ADDR:    if (byte_done) state_d = is_read ? RD_DATA : WR_DATA;
                default: state_d = state_q;
            endcase
        end
    end

    // Bit/byte datapath, register file, write strobe and MISO shifter.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            bit_cnt     <= '0;
            shift_in    <= '0;
            shift_out   <= '0;
            is_read     <= 1'b0;
            addr        <= '0;
            snap_x      <= '0;
            snap_y      <= '0;
            snap_z      <= '0;
            o_miso      <= 1'b0;
            o_wr_strobe <= 1'b0;
            o_wr_addr   <= '0;
            o_wr_data   <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) regs[i] <= '0;
        end else begin
            o_wr_strobe <= 1'b0;
            if (cs_fall) begin
                bit_cnt <= '0;
                snap_x  <= i_xSense;
                snap_y  <= i_ySense;
                snap_z  <= i_zSense;
            end else if (sclk_rise && state_q != IDLE) begin
                shift_in <= in_byte[6:0];
                bit_cnt  <= bit_cnt + 3'd1;
            end

            if (byte_done) begin
                case (state_q)
                    CMD:     is_read <= (in_byte == CMD_READ);
                    ADDR:    addr <= in_byte[AW-1:0];
                    WR_DATA: begin
                        if (addr >= AW'(4)) regs[addr] <= in_byte;
                        o_wr_strobe <= 1'b1;
                        o_wr_addr   <= addr;
                        o_wr_data   <= in_byte;
                        addr        <= addr + 1'b1;
                    end
                    RD_DATA: addr <= addr + 1'b1;
                    default: ;
                endcase
            end

            // The fall right after a reload (bit_cnt wrapped to 0) must not shift,
            // otherwise the freshly presented MSB would be lost before the master samples it.
            if (state_d != RD_DATA) begin
                o_miso <= 1'b0;
            end else if (byte_done) begin
                o_miso    <= rd_data[7];
                shift_out <= rd_data[6:0];
            end else if (sclk_fall && bit_cnt != 3'd0) begin
                o_miso    <= shift_out[6];
                shift_out <= {shift_out[5:0], 1'b0};
            end
        end
    end

endmodule

// File: tb/tb_spi_sensor_responder.sv
// Self-checking bench for spi_sensor_responder: directed plan frames plus
// randomized frames checked against a register-map model.
module tb_spi_sensor_responder;
    localparam int H = 6; // SCLK half period in i_clk cycles

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sclk = 1'b0, cs_n = 1'b1, mosi = 1'b0;
    logic [7:0] xs = '0, ys = '0, zs = '0;
    logic       miso, miso_oe, wr_strobe, busy;
    logic [3:0] wr_addr;
    logic [7:0] wr_data;

    spi_sensor_responder #(.DEPTH(16), .DEVICE_ID(8'hAD), .CMD_WRITE(8'h0A), .CMD_READ(8'h0B)) dut (
        .i_clk(clk), .i_rst(rst_n), .i_sclk(sclk), .i_cs_n(cs_n), .i_mosi(mosi),
        .o_miso(miso), .o_miso_oe(miso_oe),
        .i_xSense(xs), .i_ySense(ys), .i_zSense(zs),
        .o_wr_strobe(wr_strobe), .o_wr_addr(wr_addr), .o_wr_data(wr_data), .o_busy(busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Model state
    logic [7:0]  mregs [16];
    logic [7:0]  snap [3];
    logic [7:0]  tx_q[$], rx_q[$], exp_rx[$];
    logic [11:0] obs_wr[$], exp_wr[$];

    always @(negedge clk) if (wr_strobe) obs_wr.push_back({wr_addr, wr_data});

    function automatic logic [7:0] model_read(input logic [3:0] a);
        if (a == 4'd0) return 8'hAD;
        if (a <= 4'd3) return snap[a - 4'd1];
        return mregs[a];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) mregs[i] = 8'h00;
    endtask

    // Expected MISO bytes and committed writes for a complete frame in tx_q.
    task automatic model_frame();
        logic [3:0] a;
        logic [7:0] cmd;
        exp_rx.delete();
        exp_wr.delete();
        cmd = tx_q[0];
        a = 4'd0;
        for (int i = 0; i < tx_q.size(); i++) begin
            if (i == 1) a = tx_q[1][3:0];
            if (i < 2) exp_rx.push_back(8'h00);
            else if (cmd == 8'h0B) begin
                exp_rx.push_back(model_read(a));
                a = a + 4'd1;
            end else if (cmd == 8'h0A) begin
                exp_rx.push_back(8'h00);
                exp_wr.push_back({a, tx_q[i]});
                if (a >= 4'd4) mregs[a] = tx_q[i];
                a = a + 4'd1;
            end else exp_rx.push_back(8'h00);
        end
    endtask

    task automatic xfer_bits(input logic [7:0] b, input int nbits, output logic [7:0] r);
        r = '0;
        for (int k = 0; k < nbits; k++) begin
            mosi = b[7-k];
            repeat (H) @(negedge clk);
            r = {r[6:0], miso};
            if (k == 0) check("busy_in_frame", busy, 1);
            sclk = 1'b1;
            repeat (H) @(negedge clk);
            sclk = 1'b0;
        end
    endtask

    task automatic cs_low(input logic [7:0] sx, input logic [7:0] sy, input logic [7:0] sz);
        xs = sx; ys = sy; zs = sz;
        snap[0] = sx; snap[1] = sy; snap[2] = sz;
        @(negedge clk);
        cs_n = 1'b0;
        repeat (H) @(negedge clk);
        check("miso_oe_low_cs", miso_oe, 1);
        xs = 8'($urandom); ys = 8'($urandom); zs = 8'($urandom);
    endtask

    task automatic cs_high();
        repeat (H) @(negedge clk);
        cs_n = 1'b1;
        repeat (8) @(negedge clk);
        check("idle_busy", busy, 0);
        check("idle_miso", miso, 0);
        check("idle_oe", miso_oe, 0);
    endtask

    task automatic run_frame(input string tag, input logic [7:0] sx, input logic [7:0] sy, input logic [7:0] sz);
        logic [7:0] r;
        snap[0] = sx; snap[1] = sy; snap[2] = sz;
        model_frame();
        rx_q.delete();
        obs_wr.delete();
        cs_low(sx, sy, sz);
        foreach (tx_q[i]) begin
            xfer_bits(tx_q[i], 8, r);
            rx_q.push_back(r);
        end
        cs_high();
        for (int i = 0; i < exp_rx.size(); i++) check({tag, "_miso"}, rx_q[i], exp_rx[i]);
        check({tag, "_nwr"}, obs_wr.size(), exp_wr.size());
        for (int i = 0; i < exp_wr.size() && i < obs_wr.size(); i++)
            check({tag, "_wr"}, obs_wr[i], exp_wr[i]);
    endtask

    initial begin
        logic [7:0] r;
        int nb;
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_miso", miso, 0);
        check("rst_oe", miso_oe, 0);
        check("rst_strobe", wr_strobe, 0);
        check("rst_busy", busy, 0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // Write reg 7 so the mid-frame reset has state to clear.
        tx_q = '{8'h0A, 8'h07, 8'h99};
        run_frame("pre_wr", 8'h00, 8'h00, 8'h00);

        // Reset during the address byte.
        cs_low(8'h00, 8'h00, 8'h00);
        xfer_bits(8'h0B, 8, r);
        xfer_bits(8'h07, 4, r);
        rst_n = 1'b0;
        #1;
        check("mid_rst_miso", miso, 0);
        check("mid_rst_oe", miso_oe, 0);
        check("mid_rst_strobe", wr_strobe, 0);
        check("mid_rst_wr_addr", wr_addr, 0);
        check("mid_rst_wr_data", wr_data, 0);
        check("mid_rst_busy", busy, 0);
        cs_n = 1'b1; sclk = 1'b0; mosi = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        tx_q = '{8'h0B, 8'h07, 8'h00};
        run_frame("rd_after_rst", 8'h00, 8'h00, 8'h00);

        tx_q = '{8'h0B, 8'h00, 8'h00};
        run_frame("read_id", 8'h00, 8'h00, 8'h00);

        tx_q = '{8'h0B, 8'h01, 8'h00, 8'h00, 8'h00};
        run_frame("burst", 8'h11, 8'h22, 8'h33);

        tx_q = '{8'h0A, 8'h0E, 8'h5A, 8'hA5, 8'h3C};
        run_frame("wr_wrap", 8'h00, 8'h00, 8'h00);
        tx_q = '{8'h0B, 8'h0E, 8'h00, 8'h00, 8'h00};
        run_frame("rd_wrap", 8'h00, 8'h00, 8'h00);

        // Abort: partial data byte must not commit.
        obs_wr.delete();
        cs_low(8'h00, 8'h00, 8'h00);
        xfer_bits(8'h0A, 8, r);
        xfer_bits(8'h05, 8, r);
        xfer_bits(8'hFF, 4, r);
        cs_high();
        check("abort_nwr", obs_wr.size(), 0);
        tx_q = '{8'h0B, 8'h05, 8'h00};
        run_frame("abort_rd", 8'h00, 8'h00, 8'h00);

        tx_q = '{8'h7F, 8'h0B, 8'h00};
        run_frame("bad_cmd", 8'h00, 8'h00, 8'h00);

        // Randomized frames.
        for (int f = 0; f < 24; f++) begin
            int unsigned sel;
            tx_q.delete();
            sel = $urandom_range(0, 3);
            if (sel < 2)       tx_q.push_back(8'h0B);
            else if (sel == 2) tx_q.push_back(8'h0A);
            else               tx_q.push_back(8'($urandom));
            tx_q.push_back(8'($urandom));
            nb = int'($urandom_range(1, 4));
            for (int i = 0; i < nb; i++) tx_q.push_back(8'($urandom));
            run_frame("rand", 8'($urandom), 8'($urandom), 8'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/spi_sensor_responder.md
Name: spi_sensor_responder

Overview:
SPI mode-0 responder that models the accelerometer side of the link, so the SPI master block can be exercised in simulation and loopback on hardware. It is fully synchronous to i_clk: SCLK, CS_n and MOSI are oversampled, not used as clocks. It decodes a command byte and an address byte, then streams register data with address auto-increment. X/Y/Z sample inputs are snapshotted at CS_n assertion so a burst read is coherent.

Parameters:
DEPTH, 16, number of 8-bit registers; power of two, >= 8
DEVICE_ID, 8'hAD, constant returned at address 0x00
CMD_WRITE, 8'h0A, write command opcode
CMD_READ, 8'h0B, read command opcode

Ports:
i_clk  input  1  system clock
i_rst  input  1  asynchronous, active-low reset
i_sclk  input  1  SPI clock from master, asynchronous to i_clk
i_cs_n  input  1  SPI chip select, active-low
i_mosi  input  1  master-out data
o_miso  output  1  slave-out data
o_miso_oe  output  1  MISO output enable; 1 while synchronized CS_n is low
i_xSense  input  8  X sample
i_ySense  input  8  Y sample
i_zSense  input  8  Z sample
o_wr_strobe  output  1  one-cycle pulse per committed write
o_wr_addr  output  $clog2(DEPTH)  address of committed write
o_wr_data  output  8  data of committed write
o_busy  output  1  high while the FSM is not in IDLE

Behaviour:
- Reset (i_rst low, async): all outputs 0, FSM IDLE, counters 0, writable registers 0, synchronizers 0 except CS_n, which resets to 1.
- i_sclk, i_cs_n and i_mosi each pass through a 2-FF synchronizer. SCLK edges are detected on the synchronized copy.
- SCLK high and low phases must each be >= 4 i_clk cycles.
- SPI timing, mode 0, MSB first:
  - MOSI is sampled on the detected SCLK rise.
  - MISO changes on the detected SCLK fall.
  - MISO is valid <= 4 i_clk cycles after the physical SCLK fall.
- Register map:
  - 0x00 = DEVICE_ID (read-only).
  - 0x01/0x02/0x03 = X/Y/Z snapshot (read-only), captured on the i_clk cycle the synchronized CS_n falls.
  - 0x04..DEPTH-1 are read/write.
  - The address byte is taken modulo DEPTH.
- FSM states: IDLE, CMD, ADDR, WR_DATA, RD_DATA, IGNORE.
  - IDLE -> CMD on synchronized CS_n fall; bit counter cleared.
  - CMD: after the 8th bit, go to ADDR if the byte equals CMD_WRITE or CMD_READ, else IGNORE.
  - ADDR: after the 8th bit, latch the address.
    - Write: go to WR_DATA.
    - Read: load the shift register with reg[addr], drive its MSB on o_miso in the same cycle, go to RD_DATA.
  - WR_DATA: each completed byte is written to reg[addr] if addr >= 4.
    - The same cycle pulses o_wr_strobe with o_wr_addr/o_wr_data, for any addr, including read-only addresses whose data is discarded.
    - addr then increments, wrapping DEPTH-1 -> 0.
  - RD_DATA: on the completion of each byte (8th rise), addr increments with wrap, and the shift register reloads from reg[addr] with its MSB presented immediately. Other falls shift left.
  - IGNORE: o_miso held 0 and MOSI ignored until CS_n rises.
- o_miso is 0 in IDLE, CMD, ADDR and WR_DATA.
- CS_n rise in any state -> IDLE next cycle. A partial byte is discarded, no write is committed and o_miso goes to 0.
- A read burst and a write burst never overlap; one transaction per CS_n frame.
- SCLK edges while CS_n is high are ignored.
- If a CS_n fall and an SCLK edge are detected in the same cycle, the CS_n fall takes priority and that edge is ignored.

Test Plan:
- Reset mid-frame: assert i_rst during the ADDR byte -> all outputs 0 and FSM IDLE; the next frame works normally.
- Read ID: frame 0x0B, 0x00, then 1 dummy byte -> MISO returns 0xAD; o_busy high for the whole frame.
- Coherent burst:
  - Setup: i_xSense/ySense/zSense = 0x11/0x22/0x33.
  - Stimulus: frame 0x0B, 0x01, then 3 dummy bytes; change the inputs to 0xFF after CS_n falls.
  - Required response: MISO returns 0x11, 0x22, 0x33.
- Write then wrap-read:
  - Write phase: frame 0x0A, 0x0E, data 0x5A, 0xA5, 0x3C. Required response: strobes at addresses 14, 15, 0 with the matching data; reg 0 stays 0xAD.
  - Read phase: frame 0x0B, 0x0E, then 3 dummy bytes. Required response: MISO returns 0x5A, 0xA5, 0xAD.
- Abort: frame 0x0A, 0x05, then 4 bits, then CS_n high -> no o_wr_strobe; a later read of 0x05 returns 0x00.
- Bad command: frame 0x7F, then 2 bytes -> o_miso stays 0, no strobe, and the FSM returns to IDLE after CS_n rises.
